// File: rtl/usb3_crc_stream.sv
// Streaming CRC engine: folds up to DATA_BYTES enabled bytes per beat into a CRC and reports the transmit-form CRC and length per frame.
// Latency: result (out_valid/out_crc/out_len) appears one cycle after the accepted last beat; full beat processed in one cycle.
// Backpressure: in_ready drops while a result is pending and out_ready=1 is not seen; init also blocks input. Optional macro USB3_CRC_STREAM_CHECK_EN adds out_match.
module usb3_crc_stream #(
    parameter int                DATA_BYTES = 4,
    parameter int                CRC_W      = 32,
    parameter logic [31:0]       POLY       = 32'h04C11DB7,
    parameter logic [CRC_W-1:0]  INIT       = {CRC_W{1'b1}},
    parameter logic [31:0]       RESIDUE    = 32'hC704DD7B
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_be,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CRC_W-1:0]        out_crc,
    output logic [15:0]             out_len
`ifdef USB3_CRC_STREAM_CHECK_EN
    ,
    output logic                    out_match
`endif
);

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [15:0]        len_q, len_d;
    logic [CRC_W-1:0]   out_crc_q, out_crc_d;
    logic [15:0]        out_len_q, out_len_d;

    logic [CRC_W-1:0]   crc_nxt;
    logic [CRC_W-1:0]   crc_tx;
    logic [3:0]         byte_cnt;
    logic [16:0]        len_sum;
    logic [15:0]        len_nxt;
    logic               fb;
    logic               accept;

`ifdef USB3_CRC_STREAM_CHECK_EN
    localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];
    logic match_q, match_d;
    logic match_nxt;
    assign match_nxt = (crc_nxt == RESIDUE_W);
    assign out_match = match_q;
`endif

    // Fold every enabled byte of the beat, ascending byte index, LSB first; holes are skipped.
    always_comb begin
        crc_nxt  = crc_q;
        byte_cnt = 4'd0;
        fb       = 1'b0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (in_be[k]) begin
                byte_cnt = byte_cnt + 4'd1;
                for (int b = 0; b < 8; b++) begin
                    fb      = crc_nxt[CRC_W-1] ^ in_data[8*k+b];
                    crc_nxt = {crc_nxt[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : {CRC_W{1'b0}});
                end
            end
        end
    end

    // Transmit form is the complemented, bit-reversed register.
    always_comb begin
        crc_tx = '0;
        for (int i = 0; i < CRC_W; i++) begin
            crc_tx[i] = ~crc_nxt[CRC_W-1-i];
        end
    end

    // Frame length saturates instead of wrapping.
    always_comb begin
        len_sum = {1'b0, len_q} + {13'd0, byte_cnt};
        len_nxt = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    assign in_ready  = reset_n & ~init & ((state_q != HOLD) | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_crc   = out_crc_q;
    assign out_len   = out_len_q;

    // Next-state: init restarts the open frame but never drops a pending result; a last beat latches the result and reloads.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        out_crc_d = out_crc_q;
        out_len_d = out_len_q;
`ifdef USB3_CRC_STREAM_CHECK_EN
        match_d   = match_q;
`endif
        if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
        if (init) begin
            crc_d = INIT;
            len_d = 16'd0;
            if (state_q != HOLD) begin
                state_d = IDLE;
            end
        end else if (accept) begin
            if (in_last) begin
                out_crc_d = crc_tx;
                out_len_d = len_nxt;
`ifdef USB3_CRC_STREAM_CHECK_EN
                match_d   = match_nxt;
`endif
                crc_d     = INIT;
                len_d     = 16'd0;
                state_d   = HOLD;
            end else begin
                crc_d   = crc_nxt;
                len_d   = len_nxt;
                state_d = ACCUM;
            end
        end
    end

    // State and result registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            len_q     <= 16'd0;
            out_crc_q <= '0;
            out_len_q <= 16'd0;
`ifdef USB3_CRC_STREAM_CHECK_EN
            match_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            out_crc_q <= out_crc_d;
            out_len_q <= out_len_d;
`ifdef USB3_CRC_STREAM_CHECK_EN
            match_q   <= match_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb3_crc_stream.sv
// Testbench for usb3_crc_stream: directed and random frames against a reflected table-free CRC-32 model.
// Inputs change just after the rising edge; outputs sampled 1-2 ns after the edge.
// Optional USB3_CRC_STREAM_CHECK_EN enables out_match checks.
module tb_usb3_crc_stream;

    logic        clk = 1'b0;
    logic        reset_n, init, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_be;
    logic        in_ready, out_valid;
    logic [31:0] out_crc;
    logic [15:0] out_len;
`ifdef USB3_CRC_STREAM_CHECK_EN
    logic        out_match;
`endif

    int checks = 0;
    int errors = 0;

    byte unsigned frame[$];
    logic [31:0]  exp_crc;
    logic [15:0]  exp_len;
    logic         exp_match;
    logic [31:0]  rnd;

    always #5 clk = ~clk;

    usb3_crc_stream dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_be     (in_be),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_len   (out_len)
`ifdef USB3_CRC_STREAM_CHECK_EN
        ,
        .out_match (out_match)
`endif
    );

    // Standard reflected CRC-32 over a byte list; returns the register before the final inversion.
    function automatic logic [31:0] ref_reg(input byte unsigned q[$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [3:0] be, input logic last);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) frame.push_back(d[8*k +: 8]);
        end
        if (last) begin
            r         = ref_reg(frame);
            exp_crc   = ~r;
            exp_len   = (frame.size() > 65535) ? 16'hFFFF : 16'(frame.size());
            exp_match = (r == 32'hDEBB20E3);
            frame.delete();
        end
    endtask

    // Present one beat, wait (bounded) for in_ready, and hand it to the model once accepted.
    task automatic beat(input logic [31:0] d, input logic [3:0] be, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_be    = be;
        in_last  = last;
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        if (guard < 50) model_accept(d, be, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec9();
        beat(32'h34333231, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'h00000039, 4'h1, 1'b1);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_crc"},   out_crc,            exp_crc);
        chk({tag, "_len"},   {16'd0, out_len},   {16'd0, exp_len});
`ifdef USB3_CRC_STREAM_CHECK_EN
        chk({tag, "_match"}, {31'd0, out_match}, {31'd0, exp_match});
`endif
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; init = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; in_data = '0; in_be = '0;

        // Reset values
        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_crc",   out_crc,            32'd0);
        chk("rst_out_len",   {16'd0, out_len},   32'd0);
        #10 reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle_cycle();

        // Check value "123456789"
        send_vec9();
        chk("vec9_valid", {31'd0, out_valid}, 32'd1);
        chk("vec9_crc",   out_crc,            32'hCBF43926);
        chk("vec9_len",   {16'd0, out_len},   32'd9);
        idle_cycle();
        chk("vec9_consumed", {31'd0, out_valid}, 32'd0);

        // Payload followed by its own CRC yields the residue
        beat(32'h34333231, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1);
        check_result("resid");
        chk("resid_len13", {16'd0, out_len}, 32'd13);
`ifdef USB3_CRC_STREAM_CHECK_EN
        chk("resid_match1", {31'd0, out_match}, 32'd1);
`endif
        beat(32'h34333230, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1);
        check_result("flip");
`ifdef USB3_CRC_STREAM_CHECK_EN
        chk("flip_match0", {31'd0, out_match}, 32'd0);
`endif
        idle_cycle();

        // Result held under backpressure, then replaced without a bubble
        out_ready = 1'b0;
        send_vec9();
        rnd      = $urandom;
        in_valid = 1'b1; in_data = rnd; in_be = 4'hF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_crc",       out_crc,            32'hCBF43926);
            chk("hold_len",       {16'd0, out_len},   32'd9);
            idle_cycle();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        model_accept(rnd, 4'hF, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check_result("replace");
        chk("replace_len4", {16'd0, out_len}, 32'd4);
        idle_cycle();
        chk("replace_consumed", {31'd0, out_valid}, 32'd0);

        // init mid-frame: discards bytes and the beat presented with it
        beat($urandom, 4'hF, 1'b0);
        beat($urandom, 4'hF, 1'b0);
        init = 1'b1; in_valid = 1'b1; in_data = $urandom; in_be = 4'hF; in_last = 1'b0;
        #1;
        chk("init_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        init = 1'b0; in_valid = 1'b0;
        frame.delete();
        send_vec9();
        chk("init_vec9_crc", out_crc,          32'hCBF43926);
        chk("init_vec9_len", {16'd0, out_len}, 32'd9);
        idle_cycle();

        // init while a result is pending leaves the result intact
        out_ready = 1'b0;
        beat($urandom, 4'hF, 1'b1);
        init = 1'b1;
        idle_cycle();
        init = 1'b0;
        check_result("init_hold");
        out_ready = 1'b1;
        idle_cycle();

        // Zero-byte frame and holes in the enable pattern
        beat(32'h34333231, 4'h0, 1'b1);
        chk("empty_crc", out_crc,          32'h00000000);
        chk("empty_len", {16'd0, out_len}, 32'd0);
        beat(32'h34333231, 4'b0101, 1'b1);
        check_result("holes");
        chk("holes_len2", {16'd0, out_len}, 32'd2);
        idle_cycle();

        // Random frames, back to back (results replaced/consumed by next beats)
        for (int f = 0; f < 25; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                beat($urandom, 4'($urandom_range(0, 15)), b == nb - 1);
            end
            check_result("rand");
        end
        idle_cycle();

        // Length saturation
        for (int i = 0; i < 16400; i++) begin
            beat($urandom, 4'hF, i == 16399);
        end
        check_result("sat");
        chk("sat_len", {16'd0, out_len}, 32'h0000FFFF);
        idle_cycle();

        // Reset in HOLD drops the result at once
        beat($urandom, 4'hF, 1'b1);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_hold_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_hold_crc",      out_crc,            32'd0);
        chk("rst_hold_in_ready", {31'd0, in_ready},  32'd0);
        frame.delete();
        @(negedge clk); reset_n = 1'b1;
        idle_cycle();

        // Reset mid-frame discards partial bytes
        beat($urandom, 4'hF, 1'b0);
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        frame.delete();
        idle_cycle();
        send_vec9();
        chk("after_rst_crc", out_crc,          32'hCBF43926);
        chk("after_rst_len", {16'd0, out_len}, 32'd9);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
